// File: rtl/serial_to_parallel_pkg.sv
// Shared types and helpers for the serial_to_parallel deserializer.
// Optional parity support is compiled in with the SER2PAR_PARITY_EN macro.
package serial_to_parallel_pkg;

  // Collection phases: data bits, then (optionally) the trailing parity bit.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } s2p_state_e;

  // Width of the bit counter for a word of 'width' bits (width >= 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  // XOR of all data bits; unused upper bits must be zero.
  function automatic logic data_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ser2par_out_reg.sv
// Valid/ready holding register with overrun detection. A load while a word
// is held and not being accepted is dropped and flagged for one cycle.
module ser2par_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              overrun
);

  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] data_next_s;
  logic              valid_r;
  logic              valid_next_s;
  logic              overrun_r;
  logic              overrun_next_s;

  // Decide whether a completing word loads, is dropped, or the held word is consumed.
  always_comb begin
    data_next_s    = data_r;
    valid_next_s   = valid_r;
    overrun_next_s = 1'b0;
    if (load) begin
      if (!valid_r || ready) begin
        data_next_s  = load_data;
        valid_next_s = 1'b1;
      end else begin
        overrun_next_s = 1'b1;
      end
    end else if (valid_r && ready) begin
      valid_next_s = 1'b0;
    end else begin
      valid_next_s = valid_r;
    end
  end

  // Register the output word, its valid flag and the overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r    <= {DATA_W{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      data_r    <= data_next_s;
      valid_r   <= valid_next_s;
      overrun_r <= overrun_next_s;
    end
  end

  assign data    = data_r;
  assign valid   = valid_r;
  assign overrun = overrun_r;

endmodule

// File: rtl/serial_to_parallel.sv
// Deserializer: gathers WIDTH qualified bits from the D_ff stage into a word
// and presents it on a valid/ready port. Define SER2PAR_PARITY_EN to expect a
// trailing even-parity bit per word and report parity_err with the word.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din,
  input  logic                          din_valid,
  output logic [WIDTH-1:0]              dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          overrun,
`ifdef SER2PAR_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [cnt_width(WIDTH)-1:0]   bit_cnt
);

  localparam int CNT_W = cnt_width(WIDTH);
`ifdef SER2PAR_PARITY_EN
  localparam int OUT_W = WIDTH + 1;
`else
  localparam int OUT_W = WIDTH;
`endif

  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shifted_s;
  logic [CNT_W-1:0] cnt_r;
  logic             last_bit_s;
  logic             load_s;
  logic [OUT_W-1:0] load_data_s;
  logic [OUT_W-1:0] out_data_s;
`ifdef SER2PAR_PARITY_EN
  s2p_state_e       state_r;
`endif

  // Shift-register image after taking din, and detection of the word's last data bit.
  always_comb begin
    if (MSB_FIRST) begin
      shifted_s = {shift_r[WIDTH-2:0], din};
    end else begin
      shifted_s = {din, shift_r[WIDTH-1:1]};
    end
    last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
  end

`ifdef SER2PAR_PARITY_EN
  // Word is delivered on the parity bit, tagged with the even-parity check result.
  always_comb begin
    load_s      = 1'b0;
    load_data_s = {OUT_W{1'b0}};
    if ((state_r == PARITY) && din_valid) begin
      load_s      = 1'b1;
      load_data_s = {data_parity(32'(shift_r)) ^ din, shift_r};
    end else begin
      load_s = 1'b0;
    end
  end

  // Collect data bits, then wait in PARITY for the parity bit before the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      state_r <= COLLECT;
    end else begin
      case (state_r)
        COLLECT: begin
          if (din_valid) begin
            shift_r <= shifted_s;
            if (last_bit_s) begin
              cnt_r   <= {CNT_W{1'b0}};
              state_r <= PARITY;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (din_valid) begin
            state_r <= COLLECT;
          end
        end
        default: begin
          state_r <= COLLECT;
        end
      endcase
    end
  end
`else
  // Word completes on the edge that takes its last data bit.
  always_comb begin
    load_s      = 1'b0;
    load_data_s = {OUT_W{1'b0}};
    if (din_valid && last_bit_s) begin
      load_s      = 1'b1;
      load_data_s = shifted_s;
    end else begin
      load_s = 1'b0;
    end
  end

  // Take qualified bits and count them, wrapping on the word's last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (din_valid) begin
      shift_r <= shifted_s;
      if (last_bit_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end
`endif

  ser2par_out_reg #(
    .DATA_W (OUT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .load_data (load_data_s),
    .ready     (dout_ready),
    .data      (out_data_s),
    .valid     (dout_valid),
    .overrun   (overrun)
  );

`ifdef SER2PAR_PARITY_EN
  assign {parity_err, dout} = out_data_s;
`else
  assign dout = out_data_s;
`endif
  assign bit_cnt = cnt_r;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: one MSB-first and one LSB-first
// instance, a word-level reference model checked every cycle, plus literal
// checks for the directed scenarios. Honours SER2PAR_PARITY_EN.
module tb_serial_to_parallel;

`ifdef SER2PAR_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_t  [2];
  logic       dv_t   [2];
  logic       rdy_t  [2];
  logic [7:0] dout_t [2];
  logic       val_t  [2];
  logic       ovr_t  [2];
  logic [2:0] cnt_t  [2];
`ifdef SER2PAR_PARITY_EN
  logic       perr_t [2];
`endif

  int n_chk = 0;
  int n_err = 0;
  int vcnt0;
  logic [7:0] cap0;

  // Reference model state per instance
  int         m_cnt   [2];
  logic [8:0] m_bits  [2];
  logic       m_valid [2];
  logic [7:0] m_dout  [2];
  logic       m_ovr   [2];
  logic       m_perr  [2];

  always #5 clk = ~clk;

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din_t[0]), .din_valid(dv_t[0]),
    .dout(dout_t[0]), .dout_valid(val_t[0]), .dout_ready(rdy_t[0]),
    .overrun(ovr_t[0]),
`ifdef SER2PAR_PARITY_EN
    .parity_err(perr_t[0]),
`endif
    .bit_cnt(cnt_t[0]));

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din_t[1]), .din_valid(dv_t[1]),
    .dout(dout_t[1]), .dout_valid(val_t[1]), .dout_ready(rdy_t[1]),
    .overrun(ovr_t[1]),
`ifdef SER2PAR_PARITY_EN
    .parity_err(perr_t[1]),
`endif
    .bit_cnt(cnt_t[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_bits[k] = 9'd0; m_valid[k] = 1'b0;
      m_dout[k] = 8'd0; m_ovr[k] = 1'b0; m_perr[k] = 1'b0;
    end
  endtask

  // Word-level model: a list of received bits, turned into a word when full.
  task automatic model_step(input int k, input logic d, input logic dv, input logic rdy);
    logic       done;
    logic       perr;
    logic [7:0] w;
    done = 1'b0;
    perr = 1'b0;
    if (dv) begin
      if (m_cnt[k] < 8) begin
        m_bits[k][m_cnt[k]] = d;
        m_cnt[k]++;
        if (m_cnt[k] == 8 && !PAR) begin
          done = 1'b1;
          m_cnt[k] = 0;
        end
      end else begin
        done = 1'b1;
        perr = ((($countones(m_bits[k][7:0]) + int'(d)) % 2) != 0);
        m_cnt[k] = 0;
      end
    end
    w = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (k == 0) w[7-i] = m_bits[k][i];
      else        w[i]   = m_bits[k][i];
    end
    m_ovr[k] = 1'b0;
    if (done) begin
      if (!m_valid[k] || rdy) begin
        m_dout[k] = w; m_valid[k] = 1'b1; m_perr[k] = perr;
      end else begin
        m_ovr[k] = 1'b1;
      end
    end else if (m_valid[k] && rdy) begin
      m_valid[k] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_step(k, din_t[k], dv_t[k], rdy_t[k]);
    if (val_t[0]) begin
      vcnt0++;
      cap0 = dout_t[0];
    end
  endtask

  // Sends one word on instance k in that instance's bit order (plus parity bit if built in).
  task automatic send_word(input int k, input logic [7:0] w, input int gap,
                           input bit rdy_last, input bit bad_par);
    logic b [9];
    int   n;
    for (int i = 0; i < 8; i++) b[i] = (k == 0) ? w[7-i] : w[i];
    b[8] = (^w) ^ bad_par;
    n = PAR ? 9 : 8;
    for (int i = 0; i < n; i++) begin
      if (rdy_last && i == n - 1) rdy_t[k] = 1'b1;
      din_t[k] = b[i]; dv_t[k] = 1'b1;
      step();
      dv_t[k] = 1'b0; din_t[k] = 1'b0;
      if (i != n - 1) repeat (gap) step();
    end
  endtask

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d dout_valid", k), 32'(val_t[k]), 32'(m_valid[k]));
      check($sformatf("u%0d overrun", k), 32'(ovr_t[k]), 32'(m_ovr[k]));
      check($sformatf("u%0d bit_cnt", k), 32'(cnt_t[k]), 32'(m_cnt[k] % 8));
      if (m_valid[k]) begin
        check($sformatf("u%0d dout", k), 32'(dout_t[k]), 32'(m_dout[k]));
`ifdef SER2PAR_PARITY_EN
        check($sformatf("u%0d parity_err", k), 32'(perr_t[k]), 32'(m_perr[k]));
`endif
      end
    end
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      din_t[k] = 1'b0; dv_t[k] = 1'b0; rdy_t[k] = 1'b1;
    end
    rdy_t[0] = 1'b0;
    vcnt0 = 0;
    cap0  = 8'd0;
    #12;
    check("reset dout", 32'(dout_t[0]), 32'h0);
    check("reset dout_valid", 32'(val_t[0]), 32'h0);
    check("reset overrun", 32'(ovr_t[0]), 32'h0);
    check("reset bit_cnt", 32'(cnt_t[0]), 32'h0);
    rst_n = 1'b1;
    step(); step();

    // Partial word, then asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      din_t[0] = (i != 1); dv_t[0] = 1'b1;
      step();
    end
    dv_t[0] = 1'b0; din_t[0] = 1'b0;
    check("partial bit_cnt", 32'(cnt_t[0]), 32'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async rst bit_cnt", 32'(cnt_t[0]), 32'h0);
    check("async rst dout_valid", 32'(val_t[0]), 32'h0);
    check("async rst dout", 32'(dout_t[0]), 32'h0);
    #2;
    rst_n = 1'b1;
    step();
    check("no word on release", 32'(val_t[0]), 32'h0);
    send_word(0, 8'hA5, 0, 1'b0, 1'b0);
    check("A5 dout", 32'(dout_t[0]), 32'hA5);
    check("A5 dout_valid", 32'(val_t[0]), 32'h1);
    rdy_t[0] = 1'b1;
    step(); step();

    // Gapped input with the consumer always ready
    vcnt0 = 0;
    send_word(0, 8'h3C, 2, 1'b0, 1'b0);
    repeat (3) step();
    check("gapped valid cycles", 32'(vcnt0), 32'd1);
    check("gapped dout", 32'(cap0), 32'h3C);

    // LSB-first instance
    send_word(1, 8'h01, 0, 1'b0, 1'b0);
    check("lsb dout", 32'(dout_t[1]), 32'h01);
    check("lsb dout_valid", 32'(val_t[1]), 32'h1);
    step();

    // Backpressure and overrun
    rdy_t[0] = 1'b0;
    send_word(0, 8'h11, 0, 1'b0, 1'b0);
    send_word(0, 8'h22, 0, 1'b0, 1'b0);
    check("overrun pulse", 32'(ovr_t[0]), 32'h1);
    check("overrun dout held", 32'(dout_t[0]), 32'h11);
    step();
    check("overrun one cycle", 32'(ovr_t[0]), 32'h0);
    check("held dout_valid", 32'(val_t[0]), 32'h1);
    rdy_t[0] = 1'b1;
    step();
    check("accept clears valid", 32'(val_t[0]), 32'h0);

    // Same-edge accept and completion
    rdy_t[0] = 1'b0;
    send_word(0, 8'h55, 0, 1'b0, 1'b0);
    send_word(0, 8'h66, 0, 1'b1, 1'b0);
    check("same-edge dout", 32'(dout_t[0]), 32'h66);
    check("same-edge dout_valid", 32'(val_t[0]), 32'h1);
    check("same-edge overrun", 32'(ovr_t[0]), 32'h0);
    step();
    check("same-edge accepted", 32'(val_t[0]), 32'h0);

`ifdef SER2PAR_PARITY_EN
    // Parity: good parity bit, word only after the parity bit, then a bad one
    rdy_t[0] = 1'b1;
    step();
    begin
      logic [7:0] w07;
      w07 = 8'h07;
      for (int i = 0; i < 8; i++) begin
        din_t[0] = w07[7-i]; dv_t[0] = 1'b1;
        step();
      end
    end
    dv_t[0] = 1'b0;
    check("par no word before parity", 32'(val_t[0]), 32'h0);
    din_t[0] = 1'b1; dv_t[0] = 1'b1;
    step();
    dv_t[0] = 1'b0; din_t[0] = 1'b0;
    check("par good dout_valid", 32'(val_t[0]), 32'h1);
    check("par good dout", 32'(dout_t[0]), 32'h07);
    check("par good parity_err", 32'(perr_t[0]), 32'h0);
    step();
    send_word(0, 8'h07, 0, 1'b0, 1'b1);
    check("par bad dout", 32'(dout_t[0]), 32'h07);
    check("par bad parity_err", 32'(perr_t[0]), 32'h1);
    step();
`endif

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
